// File: rtl/seq_control_unit.sv
// seq_control_unit: multi-cycle sequencer that turns opcodes into registered
// datapath control strobes (IDLE -> DECODE -> EXEC -> [MEM|IO_WAIT] -> [WB]).
// Optional feature macro: SEQCU_UART_OPS_EN enables the rcv/snd/baud UART opcodes.
// Handshake: an opcode is taken on a rising edge where instr_valid && instr_ready;
// instr_ready is high only in IDLE. io_req is held until io_ack is sampled.
module seq_control_unit #(
  parameter int OPW        = 6,
  parameter int ACW        = 6,
  parameter int MEM_WAIT   = 1,
  parameter int IO_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] opcode,
  input  logic           io_ack,
  output logic           io_req,
  output logic           regDest,
  output logic           regWrite,
  output logic           aluSrc,
  output logic           memRead,
  output logic           memWrite,
  output logic           memToReg,
  output logic           branch,
  output logic           jmp,
  output logic           jr,
  output logic           jal,
  output logic           hlt,
  output logic           busy,
  output logic           timeout_err,
  output logic           illegal_op,
  output logic [ACW-1:0] aluCtrl,
  output logic [2:0]     uartc,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_MEM, S_IO_WAIT, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_RALU, C_ADDI, C_LW, C_SW, C_BEQ, C_JMP, C_JR, C_JAL, C_IN, C_IO_NWB, C_HALT
  } cls_t;

  typedef struct packed {
    logic           rdy;
    logic           busy;
    logic           reg_dest;
    logic           reg_write;
    logic           alu_src;
    logic           mem_read;
    logic           mem_write;
    logic           mem_to_reg;
    logic           branch;
    logic           jmp;
    logic           jr;
    logic           jal;
    logic           hlt;
    logic           io_req;
    logic [2:0]     uartc;
    logic [ACW-1:0] alu_ctrl;
  } ctrl_t;

  localparam logic [3:0]  MW  = 4'(MEM_WAIT);
  localparam logic [16:0] IOT = 17'(IO_TIMEOUT);

  state_t         state, next_state;
  cls_t           cls;
  logic [OPW-1:0] opcode_q;
  logic [5:0]     op6;
  logic           hi_nz, is_ill, set_to;
  logic [2:0]     uart_cmd;
  logic [3:0]     mem_cnt, mem_cnt_n;
  logic [15:0]    io_cnt, io_cnt_n;
  logic [16:0]    io_cnt_p1;
  ctrl_t          ctrl_n, ctrl_q;

  assign op6       = opcode_q[5:0];
  assign io_cnt_p1 = {1'b0, io_cnt} + 17'd1;
  assign dbg_state = state;

  generate
    if (OPW > 6) begin : g_hi
      assign hi_nz = |opcode_q[OPW-1:6];
    end else begin : g_nohi
      assign hi_nz = 1'b0;
    end
  endgenerate

  // Classify the latched opcode; unknown or wide opcodes become flagged NOPs
  always_comb begin
    cls      = C_NOP;
    is_ill   = 1'b0;
    uart_cmd = 3'b000;
    case (op6)
      6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
      6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b001011: cls = C_RALU;
      6'b001100: cls = C_ADDI;
      6'b001110: cls = C_LW;
      6'b010000: cls = C_SW;
      6'b010001: cls = C_BEQ;
      6'b011010: cls = C_JMP;
      6'b011001: cls = C_JR;
      6'b100001: cls = C_JAL;
      6'b100101: cls = C_IN;
      6'b011101: cls = C_HALT;
      6'b011100: cls = C_NOP;
`ifdef SEQCU_UART_OPS_EN
      6'b101111: begin cls = C_IN;     uart_cmd = 3'b010; end
      6'b101110: begin cls = C_IO_NWB; uart_cmd = 3'b011; end
      6'b101101: begin cls = C_IO_NWB; uart_cmd = 3'b100; end
`endif
      default:   is_ill = 1'b1;
    endcase
    if (hi_nz) begin
      cls      = C_NOP;
      is_ill   = 1'b1;
      uart_cmd = 3'b000;
    end
  end

  // Next state and wait counters
  always_comb begin
    next_state = state;
    mem_cnt_n  = mem_cnt;
    io_cnt_n   = io_cnt;
    set_to     = 1'b0;
    case (state)
      S_IDLE:   if (instr_valid) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        case (cls)
          C_RALU, C_ADDI: next_state = S_WB;
          C_LW, C_SW:     begin next_state = S_MEM;     mem_cnt_n = 4'd0;  end
          C_IN, C_IO_NWB: begin next_state = S_IO_WAIT; io_cnt_n  = 16'd0; end
          C_HALT:         next_state = S_HALT;
          default:        next_state = S_IDLE;
        endcase
      end
      S_MEM: begin
        if (mem_cnt == MW) next_state = (cls == C_LW) ? S_WB : S_IDLE;
        else               mem_cnt_n  = mem_cnt + 4'd1;
      end
      S_IO_WAIT: begin
        // io_ack on the final allowed cycle still wins over the timeout
        if (io_ack) next_state = (cls == C_IN) ? S_WB : S_IDLE;
        else if (io_cnt_p1 == IOT) begin
          next_state = S_IDLE;
          set_to     = 1'b1;
        end else io_cnt_n = io_cnt_p1[15:0];
      end
      S_WB:    next_state = S_IDLE;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  // Controls for the state being entered, so they can be registered cleanly
  always_comb begin
    ctrl_n = '0;
    case (next_state)
      S_IDLE: ctrl_n.rdy = 1'b1;
      S_EXEC: begin
        case (cls)
          C_RALU: begin ctrl_n.reg_dest = 1'b1; ctrl_n.alu_ctrl[5:0] = op6; end
          C_ADDI: ctrl_n.alu_src = 1'b1;
          C_BEQ:  ctrl_n.branch  = 1'b1;
          C_JMP:  ctrl_n.jmp     = 1'b1;
          C_JR:   ctrl_n.jr      = 1'b1;
          C_JAL:  begin ctrl_n.jmp = 1'b1; ctrl_n.jal = 1'b1; end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl_n.mem_read  = (cls == C_LW);
        ctrl_n.mem_write = (cls == C_SW) && (mem_cnt_n == MW);
      end
      S_IO_WAIT: begin
        ctrl_n.io_req = 1'b1;
        ctrl_n.uartc  = uart_cmd;
      end
      S_WB: begin
        ctrl_n.reg_write = 1'b1;
        case (cls)
          C_RALU: begin ctrl_n.reg_dest = 1'b1; ctrl_n.alu_ctrl[5:0] = op6; end
          C_ADDI: ctrl_n.alu_src    = 1'b1;
          C_LW:   ctrl_n.mem_to_reg = 1'b1;
          C_IN:   ctrl_n.alu_src    = 1'b1;
          default: ;
        endcase
      end
      S_HALT:  ctrl_n.hlt = 1'b1;
      default: ;
    endcase
    ctrl_n.busy = (next_state != S_IDLE) && (next_state != S_HALT);
  end

  // State, counters, opcode latch, sticky flags and registered controls
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      mem_cnt     <= 4'd0;
      io_cnt      <= 16'd0;
      opcode_q    <= '0;
      timeout_err <= 1'b0;
      illegal_op  <= 1'b0;
      ctrl_q      <= '0;
      ctrl_q.rdy  <= 1'b1;
    end else begin
      state       <= next_state;
      mem_cnt     <= mem_cnt_n;
      io_cnt      <= io_cnt_n;
      if (state == S_IDLE && instr_valid) opcode_q <= opcode;
      timeout_err <= timeout_err | set_to;
      illegal_op  <= illegal_op | ((state == S_DECODE) && is_ill);
      ctrl_q      <= ctrl_n;
    end
  end

  assign instr_ready = ctrl_q.rdy;
  assign busy        = ctrl_q.busy;
  assign regDest     = ctrl_q.reg_dest;
  assign regWrite    = ctrl_q.reg_write;
  assign aluSrc      = ctrl_q.alu_src;
  assign memRead     = ctrl_q.mem_read;
  assign memWrite    = ctrl_q.mem_write;
  assign memToReg    = ctrl_q.mem_to_reg;
  assign branch      = ctrl_q.branch;
  assign jmp         = ctrl_q.jmp;
  assign jr          = ctrl_q.jr;
  assign jal         = ctrl_q.jal;
  assign hlt         = ctrl_q.hlt;
  assign io_req      = ctrl_q.io_req;
  assign uartc       = ctrl_q.uartc;
  assign aluCtrl     = ctrl_q.alu_ctrl;

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 Parameter OPW, default 6, opcode width; must be >= 6.
REQ-002 Parameter ACW, default 6, ALU-control width; must be >= 6.
REQ-003 Parameter MEM_WAIT, default 1, extra memory wait cycles; legal range 0..15.
REQ-004 Parameter IO_TIMEOUT, default 255, maximum cycles to wait for io_ack; legal range 1..65535.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: reset  in  1  reset, synchronous, active-high.
REQ-007 Port: instr_valid  in  1  an opcode is presented.
REQ-008 Port: instr_ready  out  1  the unit accepts an opcode.
REQ-009 Port: opcode  in  OPW  instruction opcode.
REQ-010 Port: io_ack  in  1  the IO/UART peripheral has completed the request.
REQ-011 Port: io_req  out  1  IO/UART request, held until acknowledged.
REQ-012 Ports, all out, 1 bit each: regDest, regWrite, aluSrc, memRead, memWrite, memToReg, branch, jmp, jr, jal, hlt, busy, timeout_err, illegal_op.
REQ-013 Port: aluCtrl  out  ACW  ALU operation select.
REQ-014 Port: uartc  out  3  UART command: 010 = rcv, 011 = snd, 100 = baud.

Function
REQ-015 The FSM SHALL have the states IDLE, DECODE, EXEC, MEM, IO_WAIT, WB and HALT.
REQ-016 IDLE:
- instr_ready = 1 only in IDLE.
- An opcode is latched when instr_valid && instr_ready; the FSM then goes to DECODE.
REQ-017 DECODE SHALL last exactly 1 cycle and SHALL always go to EXEC.
REQ-018 Opcode decode:
- R-type ALU ops (add 000000, sub 000001, and 000010, or 000011, not 000100, sll 000101, srl 000110, mul 000111, div 001000, mod 001001, xor 001011): aluCtrl = zero-extended opcode[5:0], aluSrc = 0, regDest = 1.
- addi 001100: aluSrc = 1, regDest = 0, aluCtrl = 0.
REQ-019 Non-memory ALU ops SHALL go EXEC -> WB -> IDLE.
- regWrite pulses for exactly 1 cycle, in WB.
- Acceptance-to-next-acceptance is 4 cycles.
REQ-020 lw 001110: EXEC -> MEM; memRead is held for MEM_WAIT+1 cycles; then WB with memToReg = 1 and regWrite = 1.
REQ-021 sw 010000: EXEC -> MEM for MEM_WAIT+1 cycles; memWrite = 1 only in the final MEM cycle; then IDLE; regWrite is never asserted.
REQ-022 Single-cycle pulses in EXEC, followed by IDLE:
- beq 010001: branch.
- jmp 011010: jmp.
- jr 011001: jr.
- jal 100001: jmp and jal.
REQ-023 input 100101: EXEC -> IO_WAIT with io_req = 1.
- io_ack SHALL move the FSM to WB with aluSrc = 1 and regWrite = 1.
REQ-024 IO_WAIT timeout:
- A counter increments each IO_WAIT cycle.
- On reaching IO_TIMEOUT without io_ack: sticky timeout_err = 1, FSM returns to IDLE, no WB.
- If io_ack arrives in the same cycle the count reaches IO_TIMEOUT, io_ack wins and timeout_err stays 0.
REQ-025 halt 011101: FSM enters HALT; hlt = 1 there until reset; instr_ready = 0.
REQ-026 nop 011100 SHALL go EXEC -> IDLE with all controls 0.
REQ-027 Illegal opcodes (any unlisted value, or any nonzero bit above bit 5) SHALL behave as NOP and set sticky illegal_op = 1.
REQ-028 All control outputs SHALL be registered, and SHALL be 0 outside the states that assert them.
REQ-029 busy = 1 in every state except IDLE and HALT.
REQ-030 io_req SHALL fall in the cycle after io_ack is sampled.

Reset
REQ-031 reset SHALL force IDLE, clear all outputs, the timeout counter, timeout_err and illegal_op, and set instr_ready = 1 on the first cycle after reset.
REQ-032 reset asserted mid-operation SHALL abort the operation; no regWrite or memWrite pulse occurs after reset is sampled.

Configuration
REQ-033 Macro SEQCU_UART_OPS_EN.
- Defined: rcv 101111 behaves as input with uartc = 010; snd 101110 (uartc = 011) and baud 101101 (uartc = 100) use IO_WAIT without WB.
- Undefined: those three opcodes are illegal (REQ-027), and uartc is constant 000.

Verification
REQ-034 add 000000 accepted at cycle 0 -> regWrite = 1 only in cycle 3, aluCtrl = 000000, instr_ready = 1 again in cycle 4.
REQ-035 lw with MEM_WAIT = 2 -> memRead high for 3 cycles, then one WB cycle with memToReg = 1 and regWrite = 1.
REQ-036 input with io_ack never asserted, IO_TIMEOUT = 8 -> timeout_err = 1 after 8 IO_WAIT cycles, no regWrite, back to IDLE.
REQ-037 input with io_ack on exactly the 8th IO_WAIT cycle (IO_TIMEOUT = 8) -> WB occurs, timeout_err = 0.
REQ-038 Opcode 101111 -> with SEQCU_UART_OPS_EN: io_req = 1 and uartc = 010; without it: illegal_op = 1 and no io_req.
REQ-039 halt, then reset pulse during HALT -> hlt = 0 and instr_ready = 1 on the cycle after reset; sw aborted by reset mid-MEM -> memWrite never asserted.
